// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath/memory.
// The sequencer sits on the slave side; the datapath (or a bench) drives the master side.
interface multicycle_control_fsm_if #(
    parameter int OPW  = 6,
    parameter int SW_W = 4
);
    logic [OPW-1:0]  opcode;
    logic [OPW-1:0]  funct;
    logic            mem_ready;
    logic            pc_write;
    logic            pc_write_cond;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            jal;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_op;
    logic [1:0]      pc_source;
    logic [SW_W-1:0] state;

    modport master (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jal, alu_src_a, alu_src_b,
               alu_op, pc_source, state
    );

    modport slave (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jal, alu_src_a, alu_src_b,
               alu_op, pc_source, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS datapath: fetch/decode/execute/writeback
// with wait states on a shared variable-latency instruction/data memory.
module multicycle_control_fsm #(
    parameter int OPW  = 6,
    parameter int SW_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.slave   io_bus
);

    typedef enum logic [SW_W-1:0] {
        FETCH   = SW_W'(0),
        DECODE  = SW_W'(1),
        MEMADR  = SW_W'(2),
        MEMRD   = SW_W'(3),
        MEMWB   = SW_W'(4),
        MEMWR   = SW_W'(5),
        RTEXE   = SW_W'(6),
        RTWB    = SW_W'(7),
        BRANCH  = SW_W'(8),
        JUMP    = SW_W'(9),
        ADDIEXE = SW_W'(10),
        ADDIWB  = SW_W'(11),
        JALST   = SW_W'(12),
        JR      = SW_W'(13)
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_J     = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(8);
    localparam logic [OPW-1:0] OP_LW    = OPW'(35);
    localparam logic [OPW-1:0] OP_SW    = OPW'(43);
    localparam logic [OPW-1:0] FN_JR    = OPW'(8);

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_fetch_go;

    // Per-state control word; anything not listed for a state stays 0.
    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            RTEXE:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
            RTWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 3'b001;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ADDIEXE: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:  c.reg_write = 1'b1;
            JALST:   begin
                c.reg_write = 1'b1;
                c.jal       = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            JR:      begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Unused encodings fall through to FETCH so a corrupted state self-recovers.
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = io_bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (io_bus.opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = (io_bus.funct == FN_JR) ? JR : RTEXE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_J:         w_next = JUMP;
                    OP_JAL:       w_next = JALST;
                    OP_ADDI:      w_next = ADDIEXE;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (io_bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = io_bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:   w_next = io_bus.mem_ready ? FETCH : MEMWR;
            RTEXE:   w_next = RTWB;
            ADDIEXE: w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Control word is registered from the next state so it lines up with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= decodeState(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decodeState(w_next);
        end
    end

    // Fetch completes in the cycle memory answers, so IR/PC loads follow mem_ready there.
    assign w_fetch_go = (r_state == FETCH) && io_bus.mem_ready && !reset;

    assign io_bus.pc_write      = r_ctrl.pc_write | w_fetch_go;
    assign io_bus.ir_write      = w_fetch_go;
    assign io_bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign io_bus.iord          = r_ctrl.iord;
    assign io_bus.mem_read      = r_ctrl.mem_read;
    assign io_bus.mem_write     = r_ctrl.mem_write;
    assign io_bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign io_bus.reg_dst       = r_ctrl.reg_dst;
    assign io_bus.reg_write     = r_ctrl.reg_write;
    assign io_bus.jal           = r_ctrl.jal;
    assign io_bus.alu_src_a     = r_ctrl.alu_src_a;
    assign io_bus.alu_src_b     = r_ctrl.alu_src_b;
    assign io_bus.alu_op        = r_ctrl.alu_op;
    assign io_bus.pc_source     = r_ctrl.pc_source;
    assign io_bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction state walks with random
// memory wait states, async reset checks, and a negedge monitor comparing every cycle.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pw;
        logic       pwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       jal;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] ps;
    } obs_t;

    typedef struct {
        obs_t exp;
        int   tag;
    } sb_t;

    localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_JR = 3, C_BEQ = 4,
                   C_J = 5, C_JAL = 6, C_ADDI = 7, C_UNDEF = 8;

    logic clk;
    logic reset;
    sb_t  sbQ[$];
    int   errors;
    int   checks;
    int   cycle;
    int   instrTag;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a state, taken straight from the state/output table.
    function automatic obs_t expectFor(input int st, input bit rdy, input bit inReset);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mr = 1; e.asb = 2'b01; e.pw = rdy & !inReset; e.irw = rdy & !inReset; end
            1:  e.asb = 2'b11;
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.mw = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 3'b010; end
            7:  begin e.rw = 1; e.rdst = 1; end
            8:  begin e.asa = 1; e.aop = 3'b001; e.pwc = 1; e.ps = 2'b01; end
            9:  begin e.pw = 1; e.ps = 2'b10; end
            10: begin e.asa = 1; e.asb = 2'b10; end
            11: e.rw = 1;
            12: begin e.rw = 1; e.jal = 1; e.pw = 1; e.ps = 2'b10; end
            13: begin e.pw = 1; e.ps = 2'b11; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t sampleDut();
        obs_t g;
        g.st   = bus.state;
        g.pw   = bus.pc_write;
        g.pwc  = bus.pc_write_cond;
        g.iord = bus.iord;
        g.mr   = bus.mem_read;
        g.mw   = bus.mem_write;
        g.irw  = bus.ir_write;
        g.m2r  = bus.mem_to_reg;
        g.rdst = bus.reg_dst;
        g.rw   = bus.reg_write;
        g.jal  = bus.jal;
        g.asa  = bus.alu_src_a;
        g.asb  = bus.alu_src_b;
        g.aop  = bus.alu_op;
        g.ps   = bus.pc_source;
        return g;
    endfunction

    task automatic checkOutput(input sb_t item);
        obs_t got;
        got = sampleDut();
        checks++;
        if (got !== item.exp) begin
            errors++;
            $display("[TB] FAIL cycle%0d instr%0d got=%h (state %0d) expected=%h (state %0d)",
                     cycle, item.tag, got, got.st, item.exp, item.exp.st);
        end
    endtask

    // Monitor: every cycle the DUT presents a control word, compare it against the queue head.
    initial begin
        cycle = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyReset(input int nCycles);
        for (int i = 0; i < nCycles; i++) begin
            @(posedge clk);
            #1;
            reset         = 1'b1;
            bus.mem_ready = 1'(($urandom % 2));
            bus.opcode    = 6'($urandom);
            sbQ.push_back('{exp: expectFor(0, 1'b0, 1'b1), tag: instrTag});
        end
    endtask

    // One instruction: walk its state list, inserting wait cycles where memory is involved.
    task automatic applyStimulus(input int cls, input int fetchWaits, input int memWaits,
                                 input bit abortInMemrd, input logic [5:0] undefOp);
        int          seq[$];
        logic [5:0]  op;
        logic [5:0]  fn;
        int          nWait;
        bit          rdy;
        instrTag++;
        fn = 6'($urandom);
        case (cls)
            C_LW:    begin op = 6'h23; seq = '{0, 1, 2, 3, 4}; end
            C_SW:    begin op = 6'h2B; seq = '{0, 1, 2, 5}; end
            C_RT:    begin op = 6'h00; seq = '{0, 1, 6, 7}; if (fn == 6'h08) fn = 6'h20; end
            C_JR:    begin op = 6'h00; fn = 6'h08; seq = '{0, 1, 13}; end
            C_BEQ:   begin op = 6'h04; seq = '{0, 1, 8}; end
            C_J:     begin op = 6'h02; seq = '{0, 1, 9}; end
            C_JAL:   begin op = 6'h03; seq = '{0, 1, 12}; end
            C_ADDI:  begin op = 6'h08; seq = '{0, 1, 10, 11}; end
            default: begin op = undefOp; seq = '{0, 1}; end
        endcase
        foreach (seq[k]) begin
            nWait = (seq[k] == 0) ? fetchWaits : ((seq[k] == 3 || seq[k] == 5) ? memWaits : 0);
            for (int w = 0; w <= nWait; w++) begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) rdy = (w == nWait);
                else rdy = 1'(($urandom % 2));
                bus.mem_ready = rdy;
                bus.opcode    = (seq[k] == 0) ? 6'($urandom) : op;
                bus.funct     = (seq[k] == 0) ? 6'($urandom) : fn;
                if (abortInMemrd && seq[k] == 3) begin
                    bus.mem_ready = 1'b1;
                    sbQ.push_back('{exp: expectFor(0, 1'b0, 1'b1), tag: instrTag});
                    #1;
                    reset = 1'b1;
                    return;
                end
                sbQ.push_back('{exp: expectFor(seq[k], rdy, 1'b0), tag: instrTag});
            end
        end
    endtask

    function automatic logic [5:0] randomUndef();
        logic [5:0] o;
        do o = 6'($urandom);
        while (o == 6'h23 || o == 6'h2B || o == 6'h00 || o == 6'h04 ||
               o == 6'h02 || o == 6'h03 || o == 6'h08);
        return o;
    endfunction

    initial begin
        errors        = 0;
        checks        = 0;
        instrTag      = 0;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;

        applyReset(2);
        applyStimulus(C_LW, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_SW, 0, 3, 1'b0, 6'h3F);
        applyStimulus(C_RT, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_JR, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_BEQ, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_J, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_JAL, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_ADDI, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_UNDEF, 0, 0, 1'b0, 6'h3F);
        applyStimulus(C_LW, 0, 1, 1'b1, 6'h3F);
        applyReset(1);
        applyStimulus(C_LW, 2, 2, 1'b0, 6'h3F);

        for (int n = 0; n < 250; n++) begin
            int cls;
            cls = int'($urandom_range(0, 8));
            if ($urandom_range(0, 30) == 0) begin
                applyStimulus(C_LW, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                              1'b1, 6'h3F);
                applyReset(int'($urandom_range(1, 2)));
            end else begin
                applyStimulus(cls, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              1'b0, randomUndef());
            end
        end

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got=%0d pending expected=0 pending", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath: replaces the single-cycle combinational control unit with a Moore FSM.
- One instruction takes 3–5 states, plus wait states.
- Drives PC, instruction register, register-file, ALU and shared-memory enables.
- Stalls on a memory ready handshake so a single instruction/data memory with variable latency can be shared.

Parameters:
- OPW, 6, opcode and funct field width.
- SW_W, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- opcode  in  6  Instruction[31:26] from the instruction register
- funct  in  6  Instruction[5:0] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- jal  out  1  write register 31 with PC+4
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sext imm, 11 = sext imm<<2
- alu_op  out  3  000 = add, 001 = sub, 010 = R-type decode via funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- state  out  4  current state, for debug/verification

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (reset).
- While reset is high: state = FETCH (0), and pc_write, pc_write_cond, ir_write, reg_write, mem_write are all 0. Other outputs take their FETCH values.
- Outputs are decoded from the state register. The only exception: in FETCH, ir_write and pc_write equal mem_ready.
- All outputs not listed for a state are 0.
- State encodings and asserted outputs:
  - FETCH=0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) / 101011 (sw) → MEMADR
    - 000000 with funct=001000 → JR
    - other 000000 → RTEXE
    - 000100 → BRANCH
    - 000010 → JUMP
    - 000011 → JAL
    - 001000 → ADDIEXE
    - any other opcode → FETCH (treated as a NOP)
  - MEMADR=2: alu_src_a=1, alu_src_b=10, alu_op=000. lw → MEMRD; sw → MEMWR.
  - MEMRD=3: mem_read=1, iord=1. Hold until mem_ready, then → MEMWB.
  - MEMWB=4: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
  - MEMWR=5: mem_write=1, iord=1. Hold until mem_ready, then → FETCH. mem_write stays high for every cycle of the hold.
  - RTEXE=6: alu_src_a=1, alu_src_b=00, alu_op=010 → RTWB.
  - RTWB=7: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01 → FETCH.
  - JUMP=9: pc_write=1, pc_source=10 → FETCH.
  - ADDIEXE=10: alu_src_a=1, alu_src_b=10, alu_op=000 → ADDIWB.
  - ADDIWB=11: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - JAL=12: reg_write=1, jal=1, pc_write=1, pc_source=10 → FETCH.
  - JR=13: pc_write=1, pc_source=11 → FETCH.
  - Encodings 14, 15: all outputs 0; next state FETCH.
- Cycle counts with zero wait states (mem_ready=1 whenever requested):
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j, jal, jr = 3
  - undefined opcode = 2
- Each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds exactly 1 cycle.
- mem_ready is ignored in all other states.
- Reset asserted mid-instruction:
  - state → FETCH immediately, no further writes.
  - After reset deasserts, the first rising edge evaluates FETCH.
- mem_read and mem_write are never both 1 in any state.

Test Plan:
- Reset held 2 cycles, release, mem_ready=1 → state sequence 0,1; pc_write=ir_write=1 in the cycle after release; reg_write=mem_write=0 throughout reset.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; 5 cycles total.
- sw (opcode 101011), mem_ready low for 3 cycles in MEMWR → state 5 held 4 cycles with mem_write=1 each cycle, then 0; 7 cycles total.
- R-type add (funct 100000) then jr (funct 001000) → states 0,1,6,7 with alu_op=010, reg_dst=1 in state 7; then 0,1,13 with pc_source=11, pc_write=1.
- beq, j, jal → each visits 8 / 9 / 12 for one cycle; jal asserts jal=reg_write=pc_write=1 with pc_source=10; beq asserts alu_op=001, pc_write_cond=1.
- Undefined opcode 111111 → states 0,1,0, no write enables asserted; reset pulsed during state 3 → state 0 asynchronously, reg_write never asserted.
